qfifo_drain_arbiter: RTL and testbench

Round-robin drain arbiter that shares one downstream stream port among NUM_FIFOS shift-register FIFOs in the merge-tree front end. It watches each FIFO's empty and prog_full flags, grants one FIFO at a time for a bounded burst, pops its first-word-fall-through head, and forwards the words through a one-entry registered valid/ready output stage. FIFOs with prog_full asserted win over FIFOs that are merely non-empty.

---
 rtl/qfifo_drain_arbiter_if.sv | 27 ++
 rtl/qfifo_drain_arbiter.sv | 154 +++++++++++++++
 tb/tb_qfifo_drain_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/qfifo_drain_arbiter_if.sv
// Stream-side bundle of the FIFO drain arbiter: FIFO flags/heads/pops plus the
// registered valid/ready output port. The arbiter uses the master modport.
interface qfifo_drain_arbiter_if #(
  parameter int unsigned NUM_FIFOS  = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_W      = $clog2(NUM_FIFOS)
);
  logic [NUM_FIFOS-1:0]            i_fifo_empty;
  logic [NUM_FIFOS-1:0]            i_fifo_prog_full;
  logic [NUM_FIFOS*DATA_WIDTH-1:0] i_fifo_dout;
  logic [NUM_FIFOS-1:0]            o_fifo_rd_en;
  logic [DATA_WIDTH-1:0]           o_data;
  logic [IDX_W-1:0]                o_src;
  logic                            o_valid;
  logic                            i_ready;
  logic                            o_busy;

  modport master (
    input  i_fifo_empty, i_fifo_prog_full, i_fifo_dout, i_ready,
    output o_fifo_rd_en, o_data, o_src, o_valid, o_busy
  );

  modport slave (
    output i_fifo_empty, i_fifo_prog_full, i_fifo_dout, i_ready,
    input  o_fifo_rd_en, o_data, o_src, o_valid, o_busy
  );
endinterface

// File: rtl/qfifo_drain_arbiter.sv
// Round-robin burst drain arbiter: grants one FWFT FIFO at a time (prog_full
// FIFOs first), pops up to MAX_BURST words into a one-entry registered output.
module qfifo_drain_arbiter #(
  parameter int unsigned NUM_FIFOS  = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 4
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  qfifo_drain_arbiter_if.master bus
);

  localparam int unsigned IDX_W = $clog2(NUM_FIFOS);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      rr_q, rr_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [NUM_FIFOS-1:0]  req_urgent;
  logic [NUM_FIFOS-1:0]  req_any;
  logic [NUM_FIFOS-1:0]  sel_set;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_found;
  logic [IDX_W-1:0]      cand;
  int unsigned           j;

  logic [DATA_WIDTH-1:0] heads [NUM_FIFOS];
  logic                  head_empty;
  logic                  load_ok;
  logic                  pop;
  logic                  last_pop;
  logic [IDX_W-1:0]      rr_after_grant;

  logic [DATA_WIDTH-1:0] data_q;
  logic [IDX_W-1:0]      src_q;
  logic                  valid_q;

  for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_head
    assign heads[g] = bus.i_fifo_dout[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign req_urgent = ~bus.i_fifo_empty & bus.i_fifo_prog_full;
  assign req_any    = ~bus.i_fifo_empty;
  assign sel_set    = (|req_urgent) ? req_urgent : req_any;

  // First requester at or above rr_q, wrapping modulo NUM_FIFOS.
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    cand       = '0;
    j          = 0;
    for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
      j = 32'(rr_q) + i;
      if (j >= NUM_FIFOS) j = j - NUM_FIFOS;
      cand = IDX_W'(j);
      if (!pick_found && sel_set[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign head_empty     = bus.i_fifo_empty[grant_q];
  assign load_ok        = ~valid_q | bus.i_ready;
  assign pop            = (state_q == BURST) & ~head_empty & load_ok;
  assign last_pop       = pop & (cnt_q == CNT_W'(MAX_BURST - 1));
  assign rr_after_grant = (grant_q == IDX_W'(NUM_FIFOS - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    bus.o_fifo_rd_en = '0;
    if (pop) bus.o_fifo_rd_en[grant_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        // A drained head ends the burst without a pop; otherwise only the
        // MAX_BURST-th pop ends it. Backpressure leaves everything held.
        if (head_empty) begin
          state_d = IDLE;
          rr_d    = rr_after_grant;
        end else if (last_pop) begin
          state_d = IDLE;
          rr_d    = rr_after_grant;
          cnt_d   = '0;
        end else if (pop) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q  <= '0;
      src_q   <= '0;
      valid_q <= 1'b0;
    end else if (pop) begin
      data_q  <= heads[grant_q];
      src_q   <= grant_q;
      valid_q <= 1'b1;
    end else if (bus.i_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.o_data  = data_q;
  assign bus.o_src   = src_q;
  assign bus.o_valid = valid_q;
  assign bus.o_busy  = (state_q == BURST);

  a_rd_en_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    $onehot0(bus.o_fifo_rd_en));

  a_cnt_bound: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    cnt_q <= CNT_W'(MAX_BURST - 1));

  a_hold_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (valid_q && !bus.i_ready) |=> (valid_q && $stable(data_q) && $stable(src_q)));

endmodule

// File: tb/tb_qfifo_drain_arbiter.sv
// Directed bench for qfifo_drain_arbiter: a per-cycle vector table for the
// round-robin drain plus hand sequences for short burst, urgency, stall, reset.
module tb_qfifo_drain_arbiter;

  localparam int unsigned NF = 4;
  localparam int unsigned DW = 32;

  logic i_clk;
  logic i_rst_n;

  qfifo_drain_arbiter_if #(.NUM_FIFOS(NF), .DATA_WIDTH(DW)) bus ();

  qfifo_drain_arbiter #(
    .NUM_FIFOS (NF),
    .DATA_WIDTH(DW),
    .MAX_BURST (4)
  ) u_dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // FWFT FIFO models: empty/head follow the pointers, pops land on the edge.
  logic [DW-1:0] mem [NF][64];
  logic [5:0]    hd  [NF] = '{default: '0};
  logic [5:0]    tl  [NF] = '{default: '0};
  logic [NF-1:0] pf_en = '0;

  always_comb begin
    bus.i_fifo_empty     = '0;
    bus.i_fifo_prog_full = '0;
    bus.i_fifo_dout      = '0;
    for (int k = 0; k < NF; k++) begin
      bus.i_fifo_empty[k]       = (hd[k] == tl[k]);
      bus.i_fifo_prog_full[k]   = pf_en[k] && (6'(tl[k] - hd[k]) >= 6'd4);
      bus.i_fifo_dout[k*DW +: DW] = mem[k][hd[k]];
    end
  end

  always @(posedge i_clk) begin
    for (int k = 0; k < NF; k++)
      if (bus.o_fifo_rd_en[k]) hd[k] <= hd[k] + 6'd1;
  end

  // Accepted-word log plus a per-cycle guard against popping an empty FIFO.
  logic [33:0] acc [$];
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (bus.o_valid && bus.i_ready) acc.push_back({bus.o_src, bus.o_data});
      checks++;
      if ((bus.o_fifo_rd_en & bus.i_fifo_empty) != '0) begin
        errors++;
        $display("FAIL no_empty_read: rd_en=%b empty=%b required no overlap",
                 bus.o_fifo_rd_en, bus.i_fifo_empty);
      end
    end
  end

  typedef struct {
    logic        ready;
    logic        valid;
    logic [1:0]  src;
    logic [31:0] data;
    logic        busy;
    logic [3:0]  rd;
  } vec_t;

  vec_t rr_tab [41];

  function automatic logic [31:0] word(input int k, input int i);
    return 32'hA000_0000 + 32'(k) * 32'h100 + 32'(i);
  endfunction

  function automatic vec_t mk(input logic r, input logic v, input logic [1:0] s,
                              input logic [31:0] d, input logic b, input logic [3:0] rd);
    vec_t t;
    t.ready = r; t.valid = v; t.src = s; t.data = d; t.busy = b; t.rd = rd;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  // Apply the vector's inputs, advance one edge, compare {valid,src,data,busy,rd_en}.
  task automatic step(input string name, input vec_t v);
    bus.i_ready = v.ready;
    tick();
    check(name,
          64'({bus.o_valid, bus.o_src, bus.o_data, bus.o_busy, bus.o_fifo_rd_en}),
          64'({v.valid, v.src, v.data, v.busy, v.rd}));
  endtask

  task automatic check_now(input string name, input vec_t v);
    check(name,
          64'({bus.o_valid, bus.o_src, bus.o_data, bus.o_busy, bus.o_fifo_rd_en}),
          64'({v.valid, v.src, v.data, v.busy, v.rd}));
  endtask

  task automatic load(input int k, input int n, input int base);
    for (int i = 0; i < n; i++) begin
      mem[k][tl[k]] = word(k, base + i);
      tl[k] = tl[k] + 6'd1;
    end
  endtask

  task automatic wait_acc(input string name, input int n, input int budget);
    int cyc;
    cyc = 0;
    while (acc.size() < n && cyc < budget) begin
      tick();
      cyc++;
    end
    check({name, "_count"}, 64'(acc.size()), 64'(n));
  endtask

  task automatic check_acc(input string name, input logic [33:0] exp [$]);
    for (int i = 0; i < exp.size(); i++) begin
      if (i < acc.size()) check($sformatf("%s_w%0d", name, i), 64'(acc[i]), 64'(exp[i]));
      else                check($sformatf("%s_w%0d", name, i), 64'hDEAD, 64'(exp[i]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    logic [33:0] exp_q [$];
    int b, ph, k;

    // Round-robin schedule after reset release: burst b takes edges 5b+1..5b+5,
    // one idle/grant edge then four pops of FIFO b%4 (words 4*(b/4)..+3).
    for (int c = 1; c <= 41; c++) begin
      b  = (c - 1) / 5;
      ph = (c - 1) % 5;
      k  = b % 4;
      if (c == 41)
        rr_tab[c-1] = mk(1, 0, 2'd3, word(3, 7), 0, 4'b0000);
      else if (ph == 0 && b == 0)
        rr_tab[c-1] = mk(1, 0, 2'd0, 32'd0, 1, 4'b0001);
      else if (ph == 0)
        rr_tab[c-1] = mk(1, 0, 2'((b - 1) % 4), word((b - 1) % 4, 4 * ((b - 1) / 4) + 3),
                         1, 4'(1 << k));
      else
        rr_tab[c-1] = mk(1, 1, 2'(k), word(k, 4 * (b / 4) + ph - 1),
                         (ph != 4), (ph != 4) ? 4'(1 << k) : 4'b0000);
    end

    i_rst_n     = 1'b0;
    bus.i_ready = 1'b1;
    for (int f = 0; f < NF; f++) load(f, 8, 0);

    for (int i = 0; i < 3; i++)
      step($sformatf("reset_hold_%0d", i), mk(1, 0, 2'd0, 32'd0, 0, 4'b0000));

    @(negedge i_clk);
    i_rst_n = 1'b1;
    acc.delete();

    for (int c = 0; c < 41; c++)
      step($sformatf("rr_c%0d", c + 1), rr_tab[c]);

    // Single-word FIFO 2: one pop, exit on the empty flag next cycle.
    load(2, 1, 50);
    step("short_grant", mk(1, 0, 2'd3, word(3, 7),  1, 4'b0100));
    step("short_pop",   mk(1, 1, 2'd2, word(2, 50), 1, 4'b0000));
    step("short_exit",  mk(1, 0, 2'd2, word(2, 50), 0, 4'b0000));
    step("short_idle0", mk(1, 0, 2'd2, word(2, 50), 0, 4'b0000));
    step("short_idle1", mk(1, 0, 2'd2, word(2, 50), 0, 4'b0000));

    // Search from rr_ptr=3 wraps to FIFO 0; leaves rr_ptr at 1.
    load(0, 1, 60);
    step("wrap_grant", mk(1, 0, 2'd2, word(2, 50), 1, 4'b0001));
    step("wrap_pop",   mk(1, 1, 2'd0, word(0, 60), 1, 4'b0000));
    step("wrap_exit",  mk(1, 0, 2'd0, word(0, 60), 0, 4'b0000));

    // Urgent FIFO 3 beats FIFO 1 even though rr_ptr=1.
    acc.delete();
    pf_en[3] = 1'b1;
    load(1, 2, 100);
    load(3, 6, 100);
    step("urgent_grant", mk(1, 0, 2'd0, word(0, 60), 1, 4'b1000));
    wait_acc("urgent", 8, 40);
    exp_q = '{ {2'd3, word(3, 100)}, {2'd3, word(3, 101)}, {2'd3, word(3, 102)},
               {2'd3, word(3, 103)}, {2'd1, word(1, 100)}, {2'd1, word(1, 101)},
               {2'd3, word(3, 104)}, {2'd3, word(3, 105)} };
    check_acc("urgent", exp_q);
    pf_en[3] = 1'b0;
    repeat (4) tick();

    // Backpressure for 5 cycles after the second pop of a FIFO 0 burst.
    acc.delete();
    load(0, 4, 200);
    step("bp_grant", mk(1, 0, 2'd3, word(3, 105), 1, 4'b0001));
    step("bp_pop0",  mk(1, 1, 2'd0, word(0, 200), 1, 4'b0001));
    step("bp_pop1",  mk(1, 1, 2'd0, word(0, 201), 1, 4'b0001));
    for (int i = 0; i < 5; i++)
      step($sformatf("bp_hold%0d", i), mk(0, 1, 2'd0, word(0, 201), 1, 4'b0000));
    step("bp_pop2",  mk(1, 1, 2'd0, word(0, 202), 1, 4'b0001));
    step("bp_pop3",  mk(1, 1, 2'd0, word(0, 203), 0, 4'b0000));
    step("bp_drain", mk(1, 0, 2'd0, word(0, 203), 0, 4'b0000));
    exp_q = '{ {2'd0, word(0, 200)}, {2'd0, word(0, 201)},
               {2'd0, word(0, 202)}, {2'd0, word(0, 203)} };
    check_acc("bp", exp_q);

    // Async reset between edges after 2 pops of a FIFO 2 burst (rr_ptr=1).
    acc.delete();
    load(0, 4, 300);
    load(2, 4, 300);
    step("rst_grant", mk(1, 0, 2'd0, word(0, 203), 1, 4'b0100));
    step("rst_pop0",  mk(1, 1, 2'd2, word(2, 300), 1, 4'b0100));
    step("rst_pop1",  mk(1, 1, 2'd2, word(2, 301), 1, 4'b0100));
    #1;
    i_rst_n = 1'b0;
    #1;
    check_now("rst_immediate", mk(1, 0, 2'd0, 32'd0, 0, 4'b0000));
    step("rst_held0", mk(1, 0, 2'd0, 32'd0, 0, 4'b0000));
    step("rst_held1", mk(1, 0, 2'd0, 32'd0, 0, 4'b0000));
    @(negedge i_clk);
    i_rst_n = 1'b1;
    wait_acc("rst", 7, 40);
    exp_q = '{ {2'd2, word(2, 300)},
               {2'd0, word(0, 300)}, {2'd0, word(0, 301)}, {2'd0, word(0, 302)},
               {2'd0, word(0, 303)}, {2'd2, word(2, 302)}, {2'd2, word(2, 303)} };
    check_acc("rst", exp_q);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
